// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one SLL/SRL/SRA shifter between NUM_REQ requesters.
// Results land in a single registered slot that drains over a valid/ready port.
module shift_arbiter #(
    parameter int SHAMT_WIDTH = 5,
    parameter int NUM_REQ     = 4,
    localparam int W          = 2 ** SHAMT_WIDTH,
    localparam int IDW        = $clog2(NUM_REQ)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*W-1:0]           req_val,
    input  logic [NUM_REQ*SHAMT_WIDTH-1:0] req_shamt,
    input  logic [NUM_REQ*2-1:0]           req_op,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [W-1:0]                   rsp_data,
    output logic [IDW-1:0]                 rsp_id,
    output logic                           rsp_err
);

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;

    // Illegal op passes the operand through untouched; the error flag marks it.
    function automatic logic [W-1:0] do_shift(
        input logic [W-1:0]           v,
        input logic [SHAMT_WIDTH-1:0] s,
        input logic [1:0]             op
    );
        case (op)
            OP_SLL:  do_shift = v << s;
            OP_SRL:  do_shift = v >> s;
            OP_SRA:  do_shift = W'($signed(v) >>> s);
            default: do_shift = v;
        endcase
    endfunction

    logic                   rsp_valid_r;
    logic [W-1:0]           rsp_data_r;
    logic [IDW-1:0]         rsp_id_r;
    logic                   rsp_err_r;
    logic [IDW-1:0]         ptr_r;

    logic                   slot_free_s;
    logic                   found_s;
    logic [IDW-1:0]         gid_s;
    logic [NUM_REQ-1:0]     grant_s;
    logic [W-1:0]           g_val_s;
    logic [SHAMT_WIDTH-1:0] g_shamt_s;
    logic [1:0]             g_op_s;
    int                     idx_s;

    assign slot_free_s = !rsp_valid_r || rsp_ready;

    // Round-robin search starting at ptr_r, only while the slot can take a result.
    always_comb begin
        found_s = 1'b0;
        gid_s   = '0;
        idx_s   = 0;
        if (slot_free_s) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx_s = (int'(ptr_r) + k) % NUM_REQ;
                if (!found_s && req_valid[idx_s]) begin
                    found_s = 1'b1;
                    gid_s   = IDW'(idx_s);
                end else begin
                    found_s = found_s;
                end
            end
        end else begin
            found_s = 1'b0;
        end
    end

    // One-hot ready for the winner and operand mux feeding the shared shifter.
    always_comb begin
        grant_s = '0;
        if (found_s) begin
            grant_s[gid_s] = 1'b1;
        end else begin
            grant_s = '0;
        end
        g_val_s   = req_val[int'(gid_s)*W +: W];
        g_shamt_s = req_shamt[int'(gid_s)*SHAMT_WIDTH +: SHAMT_WIDTH];
        g_op_s    = req_op[int'(gid_s)*2 +: 2];
    end

    assign req_ready = grant_s;

    // Output slot and RR pointer; a grant wins over a plain drain so throughput stays at one per cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid_r <= 1'b0;
            rsp_data_r  <= '0;
            rsp_id_r    <= '0;
            rsp_err_r   <= 1'b0;
            ptr_r       <= '0;
        end else if (found_s) begin
            rsp_valid_r <= 1'b1;
            rsp_data_r  <= do_shift(g_val_s, g_shamt_s, g_op_s);
            rsp_id_r    <= gid_s;
            rsp_err_r   <= (g_op_s == 2'b11);
            ptr_r       <= (gid_s == IDW'(NUM_REQ - 1)) ? '0 : gid_s + IDW'(1);
        end else if (rsp_ready) begin
            rsp_valid_r <= 1'b0;
        end
    end

    assign rsp_valid = rsp_valid_r;
    assign rsp_data  = rsp_data_r;
    assign rsp_id    = rsp_id_r;
    assign rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter (SHAMT_WIDTH=5, NUM_REQ=4) with hand-computed expectations.
module tb_shift_arbiter;

    logic         clk;
    logic         reset;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [127:0] req_val;
    logic [19:0]  req_shamt;
    logic [7:0]   req_op;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [31:0]  rsp_data;
    logic [1:0]   rsp_id;
    logic         rsp_err;

    int n_total = 0;
    int n_bad   = 0;

    shift_arbiter #(.SHAMT_WIDTH(5), .NUM_REQ(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_val   (req_val),
        .req_shamt (req_shamt),
        .req_op    (req_op),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .rsp_err   (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [31:0] v, input logic [4:0] s, input logic [1:0] op);
        req_val[i*32 +: 32] = v;
        req_shamt[i*5 +: 5] = s;
        req_op[i*2 +: 2]    = op;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int exp_ids [5] = '{0, 1, 2, 3, 0};

    initial begin
        reset     = 1'b1;
        req_valid = 4'b0000;
        req_val   = '0;
        req_shamt = '0;
        req_op    = '0;
        rsp_ready = 1'b0;
        #12;
        chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_data", rsp_data, 32'd0);
        chk("rst_id", {30'd0, rsp_id}, 32'd0);
        chk("rst_err", {31'd0, rsp_err}, 32'd0);
        reset = 1'b0;

        // 1: req0 SRA
        step();
        set_req(0, 32'h8000_0001, 5'd4, 2'b10);
        req_valid = 4'b0001;
        rsp_ready = 1'b1;
        #1;
        chk("t1_ready", {28'd0, req_ready}, 32'h1);
        step();
        req_valid = 4'b0000;
        chk("t1_valid", {31'd0, rsp_valid}, 32'd1);
        chk("t1_data", rsp_data, 32'hF800_0000);
        chk("t1_id", {30'd0, rsp_id}, 32'd0);
        chk("t1_err", {31'd0, rsp_err}, 32'd0);

        // 2: req2 SLL then SRL back-to-back (ptr=1)
        set_req(2, 32'h0000_00FF, 5'd8, 2'b00);
        req_valid = 4'b0100;
        #1;
        chk("t2_ready", {28'd0, req_ready}, 32'h4);
        step();
        chk("t2_sll", rsp_data, 32'h0000_FF00);
        chk("t2_id", {30'd0, rsp_id}, 32'd2);
        set_req(2, 32'h8000_0000, 5'd31, 2'b01);
        step();
        chk("t2_srl", rsp_data, 32'h0000_0001);
        chk("t2_valid", {31'd0, rsp_valid}, 32'd1);
        req_valid = 4'b0000;

        // bring ptr to 0 via req3 (ptr=3)
        set_req(3, 32'h0000_0003, 5'd0, 2'b00);
        req_valid = 4'b1000;
        step();
        req_valid = 4'b0000;
        chk("t3pre_id", {30'd0, rsp_id}, 32'd3);
        step();
        chk("t3pre_drain", {31'd0, rsp_valid}, 32'd0);
        chk("t3pre_hold", rsp_data, 32'h0000_0003);

        // 3: all requesters valid, full throughput RR
        for (int i = 0; i < 4; i++) set_req(i, 32'h0000_0010, 5'(i), 2'b00);
        req_valid = 4'b1111;
        for (int c = 0; c < 5; c++) begin
            step();
            chk("t3_valid", {31'd0, rsp_valid}, 32'd1);
            chk("t3_id", {30'd0, rsp_id}, 32'(exp_ids[c]));
            chk("t3_data", rsp_data, 32'h0000_0010 << exp_ids[c]);
        end

        // 4: backpressure for 3 cycles (ptr=1)
        rsp_ready = 1'b0;
        #1;
        chk("t4_ready0", {28'd0, req_ready}, 32'h0);
        for (int c = 0; c < 3; c++) begin
            step();
            chk("t4_valid", {31'd0, rsp_valid}, 32'd1);
            chk("t4_data", rsp_data, 32'h0000_0010);
            chk("t4_id", {30'd0, rsp_id}, 32'd0);
            chk("t4_ready", {28'd0, req_ready}, 32'h0);
        end
        rsp_ready = 1'b1;
        #1;
        chk("t4_rel_ready", {28'd0, req_ready}, 32'h2);
        step();
        chk("t4_rel_id", {30'd0, rsp_id}, 32'd1);
        chk("t4_rel_data", rsp_data, 32'h0000_0020);

        // 5: illegal op on req1 (ptr=2)
        set_req(1, 32'h1234_5678, 5'd3, 2'b11);
        req_valid = 4'b0010;
        step();
        req_valid = 4'b0000;
        rsp_ready = 1'b0;
        chk("t5_data", rsp_data, 32'h1234_5678);
        chk("t5_err", {31'd0, rsp_err}, 32'd1);
        chk("t5_id", {30'd0, rsp_id}, 32'd1);
        chk("t5_valid", {31'd0, rsp_valid}, 32'd1);

        // 6: async reset mid-cycle, then first grant is req0
        #2;
        reset = 1'b1;
        #1;
        chk("t6_async", {31'd0, rsp_valid}, 32'd0);
        chk("t6_data", rsp_data, 32'd0);
        chk("t6_err", {31'd0, rsp_err}, 32'd0);
        #2;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) set_req(i, 32'h0000_0100, 5'd1, 2'b00);
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        #1;
        chk("t6_ready", {28'd0, req_ready}, 32'h1);
        step();
        chk("t6_id", {30'd0, rsp_id}, 32'd0);
        chk("t6_res", rsp_data, 32'h0000_0200);
        req_valid = 4'b0000;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
